// File: rtl/xbus_iob_ctl.sv
// xbus_iob_ctl: Xbus I/O-board slave with a buffered keyboard, mouse, 60 Hz tick and
// microsecond clock, exposed through a 64-word register window, plus interrupt/vector.
// Optional speaker: define XBUS_IOB_BEEP_EN to enable the beep half-period register at 44.
module xbus_iob_ctl #(
    parameter int          SYS_CLK       = 50000000,
    parameter int          HZ60_RATE     = 60,
    parameter int          US_RATE       = 1000000,
    parameter int          KB_FIFO_DEPTH = 8,
    parameter int          ACK_DELAY     = 2,
    parameter logic [21:0] BASE_ADDR     = 22'o17772000,
    parameter logic [7:0]  KB_VECTOR     = 8'o260,
    parameter logic [7:0]  CLK_VECTOR    = 8'o274
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] addr,
    input  logic [31:0] datain,
    input  logic        req,
    input  logic        write,
    output logic [31:0] dataout,
    output logic        ack,
    output logic        decode,
    output logic        interrupt,
    output logic [7:0]  vector,
    input  logic [15:0] kb_data,
    input  logic        kb_ready,
    input  logic [11:0] ms_x,
    input  logic [11:0] ms_y,
    input  logic [2:0]  ms_button,
    input  logic        ms_ready,
    output logic        beep
);

    localparam int HZ60_DIV = SYS_CLK / HZ60_RATE;
    localparam int US_DIV   = SYS_CLK / US_RATE;
    localparam int HZ_CW    = (HZ60_DIV > 1) ? $clog2(HZ60_DIV) : 1;
    localparam int US_CW    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int ACK_CW   = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam int PTR_W    = $clog2(KB_FIFO_DEPTH);

    localparam logic [5:0] OFF_KBD_LO = 6'o40;
    localparam logic [5:0] OFF_KBD_HI = 6'o41;
    localparam logic [5:0] OFF_MS_Y   = 6'o42;
    localparam logic [5:0] OFF_MS_X   = 6'o43;
    localparam logic [5:0] OFF_CSR    = 6'o45;
    localparam logic [5:0] OFF_US_LO  = 6'o50;
    localparam logic [5:0] OFF_US_HI  = 6'o51;
    localparam logic [5:0] OFF_HZ60   = 6'o52;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} bus_state_t;

    bus_state_t        state, state_next;
    logic [ACK_CW-1:0] ack_cnt;
    logic              start, rd_start, wr_start;
    logic [5:0]        reg_off;
    logic [31:0]       rd_data;

    logic [3:0]        csr;
    logic              ovf;
    logic              rdy0, rdy2;

    logic [US_CW-1:0]  us_div_cnt;
    logic              us_tick;
    logic [31:0]       us_clock;
    logic [15:0]       us_snap;

    logic [HZ_CW-1:0]  hz_div_cnt;
    logic              hz_tick, hz_en;
    logic [31:0]       hz60_clock;

    logic [15:0]       fifo_mem [KB_FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, push, pop;
    logic [31:0]       head_word;

    logic [11:0]       ms_x_q, ms_y_q;
    logic [2:0]        ms_btn_q;
    logic              ms_term, kb_term, clk_term;

    assign decode  = req & (addr[21:6] == BASE_ADDR[21:6]);
    assign reg_off = addr[5:0];

    // A transaction starts on the first decode cycle; the FSM leaves IDLE on every start
    // and only returns once decode has dropped, so this is exactly the decode rising edge.
    assign start    = (state == S_IDLE) & decode;
    assign rd_start = start & ~write;
    assign wr_start = start & write;
    assign ack      = (state == S_ACK);

    // Bus handshake state register.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Handshake next-state: wait ACK_DELAY edges from start, hold ack until decode falls.
    // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (decode) state_next = (ACK_DELAY <= 1) ? S_ACK : S_WAIT;
            S_WAIT: begin
                if (!decode)                               state_next = S_IDLE;
                else if (ack_cnt == ACK_CW'(ACK_DELAY - 1)) state_next = S_ACK;
            end
            S_ACK:  if (!decode) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Edges elapsed since start, counted while waiting to ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              ack_cnt <= '0;
        else if (start)            ack_cnt <= ACK_CW'(1);
        else if (state == S_WAIT)  ack_cnt <= ack_cnt + 1'b1;
    end

    // Microsecond divider and free-running 32-bit usec clock; LO read snapshots the top half.
    assign us_tick = (us_div_cnt == US_CW'(US_DIV - 1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            us_div_cnt <= '0;
            us_clock   <= '0;
            us_snap    <= '0;
        end else begin
            us_div_cnt <= us_tick ? '0 : us_div_cnt + 1'b1;
            if (us_tick)                           us_clock <= us_clock + 32'd1;
            if (rd_start && reg_off == OFF_US_LO) us_snap  <= us_clock[31:16];
        end
    end

    // 60 Hz divider, enabled by the first read of the tick register; tick beats read-clear.
    assign hz_tick = hz_en & (hz_div_cnt == HZ_CW'(HZ60_DIV - 1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hz_div_cnt <= '0;
            hz_en      <= 1'b0;
            hz60_clock <= '0;
            rdy2       <= 1'b0;
        end else begin
            if (hz_en) hz_div_cnt <= hz_tick ? '0 : hz_div_cnt + 1'b1;
            if (hz_tick) hz60_clock <= hz60_clock + 32'd1;
            if (rd_start && reg_off == OFF_HZ60) hz_en <= 1'b1;
            if (hz_tick)                              rdy2 <= 1'b1;
            else if (rd_start && reg_off == OFF_HZ60) rdy2 <= 1'b0;
        end
    end

    // Key FIFO: a full FIFO still accepts a key when the same cycle pops one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = rd_start & (reg_off == OFF_KBD_HI) & ~fifo_empty;
    assign push       = kb_ready & (~fifo_full | pop);
    assign head_word  = {8'b0, 5'b11111, 3'b001, fifo_mem[rd_ptr[PTR_W-1:0]]};

    // Key storage.
    // NOTE: the array has no reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= kb_data;
    end

    // FIFO pointers and sticky overflow flag (cleared by a CSR write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (kb_ready && fifo_full && !pop)       ovf <= 1'b1;
            else if (wr_start && reg_off == OFF_CSR) ovf <= 1'b0;
        end
    end

    // Interrupt enables in the CSR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            csr <= '0;
        else if (wr_start && reg_off == OFF_CSR) csr <= datain[3:0];
    end

    // Mouse latch and ready flag; a new report beats a same-cycle read-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms_x_q   <= '0;
            ms_y_q   <= '0;
            ms_btn_q <= '0;
            rdy0     <= 1'b0;
        end else begin
            if (ms_ready) begin
                ms_x_q   <= ms_x;
                ms_y_q   <= ms_y;
                ms_btn_q <= ms_button;
            end
            if (ms_ready)                             rdy0 <= 1'b1;
            else if (rd_start && reg_off == OFF_MS_Y) rdy0 <= 1'b0;
        end
    end

`ifdef XBUS_IOB_BEEP_EN
    localparam logic [5:0] OFF_BEEP = 6'o44;
    logic [15:0] beep_half;
    logic [15:0] beep_cnt;
    logic        unused_datain;
    assign unused_datain = ^datain[31:16];

    // Speaker: toggle every beep_half usec ticks; a zero half-period holds beep low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beep_half <= '0;
            beep_cnt  <= '0;
            beep      <= 1'b0;
        end else if (wr_start && reg_off == OFF_BEEP) begin
            beep_half <= datain[15:0];
            beep_cnt  <= '0;
            if (datain[15:0] == 16'd0) beep <= 1'b0;
        end else if (beep_half == 16'd0) begin
            beep_cnt <= '0;
            beep     <= 1'b0;
        end else if (us_tick) begin
            if (beep_cnt == beep_half - 16'd1) begin
                beep_cnt <= '0;
                beep     <= ~beep;
            end else begin
                beep_cnt <= beep_cnt + 16'd1;
            end
        end
    end
`else
    // Only csr[3:0] has a register behind the write data without the speaker.
    logic unused_datain;
    assign unused_datain = ^datain[31:4];
    assign beep = 1'b0;
`endif

    // Read mux for the addressed register; the raw quadrature fields of MOUSE X read 0.
    always_comb begin
        rd_data = '0;
        case (reg_off)
            OFF_KBD_LO: if (!fifo_empty) rd_data = {16'b0, head_word[15:0]};
            OFF_KBD_HI: if (!fifo_empty) rd_data = {16'b0, head_word[31:16]};
            OFF_MS_Y:   rd_data = {17'b0, ms_btn_q, ms_y_q};
            OFF_MS_X:   rd_data = {16'b0, 2'b00, 2'b00, ms_x_q};
`ifdef XBUS_IOB_BEEP_EN
            OFF_BEEP:   rd_data = {16'b0, beep_half};
`endif
            OFF_CSR:    rd_data = {23'b0, ovf, 1'b0, rdy2, ~fifo_empty, rdy0, csr};
            OFF_US_LO:  rd_data = {16'b0, us_clock[15:0]};
            OFF_US_HI:  rd_data = {16'b0, us_snap};
            OFF_HZ60:   rd_data = hz60_clock;
            default:    rd_data = '0;
        endcase
    end

    // Read data captured once at transaction start and held until the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   dataout <= '0;
        else if (start) dataout <= rd_data;
    end

    assign ms_term  = rdy0 & csr[1];
    assign kb_term  = ~fifo_empty & csr[2];
    assign clk_term = rdy2 & csr[3];

    // Registered interrupt request; keyboard/mouse vector has priority over the clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interrupt <= 1'b0;
            vector    <= '0;
        end else begin
            interrupt <= ms_term | kb_term | clk_term;
            if (ms_term | kb_term) vector <= KB_VECTOR;
            else if (clk_term)     vector <= CLK_VECTOR;
            else                   vector <= '0;
        end
    end

endmodule

// File: tb/tb_xbus_iob_ctl.sv
// tb_xbus_iob_ctl: scoreboard bench for xbus_iob_ctl. Read expectations are queued when a
// read is issued and compared against dataout when ack arrives. The usec divider is set
// to one tick per clock so the bench can model the usec clock cycle-exactly.
module tb_xbus_iob_ctl;

    localparam int          ACK_DELAY  = 2;
    localparam logic [21:0] BASE       = 22'o17772000;
    localparam logic [5:0]  O_KLO      = 6'o40;
    localparam logic [5:0]  O_KHI      = 6'o41;
    localparam logic [5:0]  O_MSY      = 6'o42;
    localparam logic [5:0]  O_MSX      = 6'o43;
    localparam logic [5:0]  O_BEEP     = 6'o44;
    localparam logic [5:0]  O_CSR      = 6'o45;
    localparam logic [5:0]  O_USLO     = 6'o50;
    localparam logic [5:0]  O_USHI     = 6'o51;
    localparam logic [5:0]  O_HZ       = 6'o52;
    localparam logic [31:0] KB_HI_WORD = 32'h0000_00F9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [21:0] addr = '0;
    logic [31:0] datain = '0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [31:0] dataout;
    logic        ack, decode, interrupt, beep;
    logic [7:0]  vector;
    logic [15:0] kb_data = '0;
    logic        kb_ready = 1'b0;
    logic [11:0] ms_x = '0;
    logic [11:0] ms_y = '0;
    logic [2:0]  ms_button = '0;
    logic        ms_ready = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];
    logic [15:0] kb_q [$];
    logic        ovf_m = 1'b0;
    logic        rdy0_m = 1'b0;
    logic        rdy2_m = 1'b0;
    logic [3:0]  csr_m = '0;
    logic [31:0] us_model;
    logic [15:0] snap_m;
    int          lat;
    int          n;

    xbus_iob_ctl #(
        .SYS_CLK(600), .HZ60_RATE(60), .US_RATE(600),
        .KB_FIFO_DEPTH(8), .ACK_DELAY(ACK_DELAY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .datain(datain), .req(req),
        .write(write), .dataout(dataout), .ack(ack), .decode(decode),
        .interrupt(interrupt), .vector(vector), .kb_data(kb_data), .kb_ready(kb_ready),
        .ms_x(ms_x), .ms_y(ms_y), .ms_button(ms_button), .ms_ready(ms_ready), .beep(beep)
    );

    always #5 clk = ~clk;

    // One usec tick per clock while out of reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) us_model <= '0;
        else          us_model <= us_model + 32'd1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expected);
        end
    endtask

    function automatic logic [31:0] csr_exp();
        return {23'b0, ovf_m, 1'b0, rdy2_m, (kb_q.size() != 0), rdy0_m, csr_m};
    endfunction

    // One bus transaction, driven from a negedge; returns on the negedge after ack drops.
    task automatic xbus_txn(input logic wr, input logic [5:0] off, input logic [31:0] wdata,
                            input int hold, input string tag, output int latency);
        logic [31:0] exp_val;
        int k;
        req = 1'b1; write = wr; addr = {BASE[21:6], off}; datain = wdata;
        k = 0;
        while (!ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        latency = k;
        check({tag, " ack"}, {31'b0, ack}, 32'd1);
        if (!wr && exp_q.size() != 0) begin
            exp_val = exp_q.pop_front();
            if (ack) check(tag, dataout, exp_val);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " ack hold"}, {31'b0, ack}, 32'd1);
        end
        req = 1'b0; write = 1'b0;
        @(negedge clk);
        check({tag, " ack drop"}, {31'b0, ack}, 32'd0);
    endtask

    task automatic rd(input logic [5:0] off, input logic [31:0] expected, input string tag);
        int l;
        exp_q.push_back(expected);
        xbus_txn(1'b0, off, 32'd0, 0, tag, l);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] data, input string tag);
        int l;
        if (off == O_CSR) begin
            csr_m = data[3:0];
            ovf_m = 1'b0;
        end
        xbus_txn(1'b1, off, data, 0, tag, l);
    endtask

    task automatic push_key(input logic [15:0] d);
        kb_ready = 1'b1; kb_data = d;
        if (kb_q.size() < 8) kb_q.push_back(d);
        else                 ovf_m = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0;
    endtask

    task automatic kbd_pair(input string tag);
        int l;
        if (kb_q.size() != 0) begin
            exp_q.push_back({16'b0, kb_q[0]});
            xbus_txn(1'b0, O_KLO, 32'd0, 0, {tag, " lo"}, l);
            exp_q.push_back(KB_HI_WORD);
            xbus_txn(1'b0, O_KHI, 32'd0, 0, {tag, " hi"}, l);
            kb_q.delete(0);
        end else begin
            exp_q.push_back(32'd0);
            xbus_txn(1'b0, O_KLO, 32'd0, 0, {tag, " lo"}, l);
            exp_q.push_back(32'd0);
            xbus_txn(1'b0, O_KHI, 32'd0, 0, {tag, " hi"}, l);
        end
    endtask

    task automatic ms_event(input logic [11:0] x, input logic [11:0] y, input logic [2:0] b);
        ms_ready = 1'b1; ms_x = x; ms_y = y; ms_button = b;
        @(negedge clk);
        ms_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state and ack latency
        check("reset dataout", dataout, 32'd0);
        check("reset ack", {31'b0, ack}, 32'd0);
        check("reset irq", {31'b0, interrupt}, 32'd0);
        check("reset vector", {24'b0, vector}, 32'd0);
        check("reset beep", {31'b0, beep}, 32'd0);
        exp_q.push_back(32'd0);
        xbus_txn(1'b0, O_CSR, 32'd0, 0, "csr after reset", lat);
        check("ack latency", lat, ACK_DELAY);

        // Overflow: nine keys into eight entries
        for (int i = 0; i < 9; i++) push_key(16'hF9A0 + 16'(i));
        rd(O_CSR, csr_exp(), "csr ovf");
        for (int i = 0; i < 8; i++) kbd_pair($sformatf("key%0d", i));
        kbd_pair("kbd empty");
        rd(O_CSR, csr_exp(), "csr drained");
        wr(O_CSR, 32'd0, "csr clear");
        rd(O_CSR, csr_exp(), "csr ovf cleared");

        // Push and pop in the same cycle while full: no overflow
        for (int i = 0; i < 8; i++) push_key(16'h1000 + 16'(i));
        exp_q.push_back(KB_HI_WORD);
        kb_q.delete(0);
        kb_q.push_back(16'h5A5A);
        fork
            xbus_txn(1'b0, O_KHI, 32'd0, 0, "khi while full", lat);
            begin
                kb_ready = 1'b1; kb_data = 16'h5A5A;
                @(negedge clk);
                kb_ready = 1'b0;
            end
        join
        rd(O_CSR, csr_exp(), "csr full push pop");
        for (int i = 0; i < 8; i++) kbd_pair($sformatf("refill%0d", i));

        // Keyboard interrupt
        wr(O_CSR, 32'h4, "csr kb enable");
        push_key(16'h1234);
        repeat (2) @(negedge clk);
        check("kb irq", {31'b0, interrupt}, 32'd1);
        check("kb vector", {24'b0, vector}, 32'o260);
        kbd_pair("kb irq key");
        check("kb irq after pop", {31'b0, interrupt}, 32'd0);

        // Mouse: report, same-cycle report and read-clear, interrupt
        wr(O_CSR, 32'h2, "csr ms enable");
        ms_event(12'h123, 12'h456, 3'b101);
        rdy0_m = 1'b1;
        repeat (2) @(negedge clk);
        check("ms irq", {31'b0, interrupt}, 32'd1);
        check("ms vector", {24'b0, vector}, 32'o260);
        rd(O_MSX, 32'h0000_0123, "ms x");
        rd(O_CSR, csr_exp(), "csr ms rdy");
        fork
            rd(O_MSY, {17'b0, 3'b101, 12'h456}, "ms y race");
            ms_event(12'h789, 12'hABC, 3'b010);
        join
        rd(O_CSR, csr_exp(), "csr rdy kept");
        rd(O_MSX, 32'h0000_0789, "ms x new");
        rd(O_MSY, {17'b0, 3'b010, 12'hABC}, "ms y new");
        rdy0_m = 1'b0;
        repeat (2) @(negedge clk);
        check("ms irq cleared", {31'b0, interrupt}, 32'd0);
        rd(O_CSR, csr_exp(), "csr rdy cleared");

        // Held decode pops once
        push_key(16'h0A01);
        push_key(16'h0A02);
        exp_q.push_back(KB_HI_WORD);
        xbus_txn(1'b0, O_KHI, 32'd0, 6, "khi held", lat);
        kb_q.delete(0);
        kbd_pair("after held");
        kbd_pair("after held empty");

        // Speaker register
`ifdef XBUS_IOB_BEEP_EN
        wr(O_BEEP, 32'd5, "beep set");
        rd(O_BEEP, 32'd5, "beep read");
        begin
            logic b0;
            b0 = beep; n = 0;
            while (beep == b0 && n < 50) begin @(negedge clk); n++; end
            b0 = beep; n = 0;
            while (beep == b0 && n < 50) begin @(negedge clk); n++; end
            check("beep half period", n, 5);
        end
        wr(O_BEEP, 32'd0, "beep stop");
        repeat (3) @(negedge clk);
        check("beep off", {31'b0, beep}, 32'd0);
`else
        wr(O_BEEP, 32'd5, "beep set");
        rd(O_BEEP, 32'd0, "beep read");
        repeat (12) @(negedge clk);
        check("beep tied", {31'b0, beep}, 32'd0);
`endif

        // 60 Hz tick: divider of 10 clocks starting at the enabling read
        rd(O_HZ, 32'd0, "hz first");
        wr(O_CSR, 32'h8, "csr clk enable");
        check("hz irq early", {31'b0, interrupt}, 32'd0);
        repeat (7) @(negedge clk);
        check("hz irq", {31'b0, interrupt}, 32'd1);
        check("hz vector", {24'b0, vector}, 32'o274);
        rd(O_HZ, 32'd1, "hz count");
        rd(O_CSR, csr_exp(), "csr hz rdy cleared");
        wr(O_CSR, 32'd0, "csr off");

        // Atomic usec read across a 16-bit carry
        while (us_model < 32'h0000_FFF0) @(negedge clk);
        snap_m = us_model[31:16];
        rd(O_USLO, {16'b0, us_model[15:0]}, "us lo");
        while (us_model < 32'h0001_0004) @(negedge clk);
        rd(O_USHI, {16'b0, snap_m}, "us hi snapshot");
        snap_m = us_model[31:16];
        rd(O_USLO, {16'b0, us_model[15:0]}, "us lo wrapped");
        rd(O_USHI, {16'b0, snap_m}, "us hi carried");

        // Reset in the middle of a held transaction
        req = 1'b1; write = 1'b0; addr = {BASE[21:6], O_CSR};
        repeat (3) @(negedge clk);
        check("ack before reset", {31'b0, ack}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("ack in reset", {31'b0, ack}, 32'd0);
        check("dataout in reset", dataout, 32'd0);
        check("irq in reset", {31'b0, interrupt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'd0);
        n = 0;
        while (!ack && n < 20) begin @(negedge clk); n++; end
        check("ack latency after reset", n, ACK_DELAY);
        if (exp_q.size() != 0) check("csr after mid reset", dataout, exp_q.pop_front());
        req = 1'b0;
        @(negedge clk);
        check("ack drop after reset", {31'b0, ack}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
